// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master.
//   i2c_state_e   : controller states, one bus phase or more per state
//   I2C_WRITE/READ: value of the R/W bit appended to the address
//   Q0..Q3        : quarter index within a bus phase
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_NACK,
    STOP
  } i2c_state_e;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_master_ctrl_quarter_tick.sv
// Quarter-period timebase for the I2C master.
// Counts CLK_DIV clocks per quarter and walks a 2-bit quarter index.
// Ports:
//   i_clk     : system clock
//   i_rst     : synchronous active-high reset
//   i_hold    : keeps counter and quarter index at zero (controller idle)
//   o_tick    : high on the last clock of each quarter
//   o_quarter : current quarter within the bus phase (Q0..Q3)
module i2c_quarter_tick #(
  parameter int CLK_DIV = 250
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_hold,
  output logic       o_tick,
  output logic [1:0] o_quarter
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       quarter;

  assign o_tick    = (cnt == CNT_LAST);
  assign o_quarter = quarter;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_hold) begin
      cnt     <= '0;
      quarter <= 2'd0;
    end else if (cnt == CNT_LAST) begin
      cnt     <= '0;
      quarter <= quarter + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, STOP.
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_start                 : transaction request, taken only when idle
//   i_rw, i_addr, i_wrdata  : direction, slave address, write byte (captured with i_start)
//   o_rddata                : byte read from the slave, updated on a completed read
//   o_busy, o_done          : transaction in progress / one-cycle completion pulse
//   o_ack_err               : NACK seen in the last transaction, held until next start
//   o_scl                   : push-pull SCL
//   io_sda                  : open-drain SDA (drives 0 or z only)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus released, SCL high, waiting for i_start
// START    | one phase: SDA falls in Q2 while SCL high, SCL falls in Q3
// ADDR     | eight phases shifting out {addr, rw}, MSB first
// ADDR_ACK | SDA released, slave ACK sampled in Q2
// WR_DATA  | eight phases shifting out the write byte, MSB first
// WR_ACK   | SDA released, slave ACK sampled in Q2
// RD_DATA  | SDA released, eight bits shifted in at the end of Q2
// RD_NACK  | SDA released (master NACK), read byte published
// STOP     | SDA low, SCL rises in Q1, SDA released in Q2
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_rw,
  input  logic [6:0] i_addr,
  input  logic [7:0] i_wrdata,
  output logic [7:0] o_rddata,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ack_err,
  output logic       o_scl,
  inout  wire        io_sda
);

  i2c_state_e state, state_nxt;

  logic       tick;
  logic [1:0] quarter;
  logic       phase_end;
  logic       smp_pt;

  logic       rw_q;
  logic [7:0] wr_byte_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt;
  logic       sda_smp;
  logic [7:0] rddata_q;
  logic       ack_err_q;
  logic       done_q;

  logic       scl;
  logic       sda_oe;

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_hold    (state == IDLE),
    .o_tick    (tick),
    .o_quarter (quarter)
  );

  assign phase_end = tick && (quarter == Q3);
  assign smp_pt    = tick && (quarter == Q2);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // In every data/ACK phase SCL is low for Q0-Q1 and high for Q2-Q3,
  // which is exactly quarter[1].
  always_comb begin
    state_nxt = state;
    scl       = 1'b1;
    sda_oe    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = START;
      end
      START: begin
        scl    = (quarter != Q3);
        sda_oe = quarter[1];
        if (phase_end) state_nxt = ADDR;
      end
      ADDR: begin
        scl    = quarter[1];
        sda_oe = ~shift_q[7];
        if (phase_end && bit_cnt == 3'd0) state_nxt = ADDR_ACK;
      end
      ADDR_ACK: begin
        scl = quarter[1];
        if (phase_end) begin
          if (sda_smp)              state_nxt = STOP;
          else if (rw_q == I2C_READ) state_nxt = RD_DATA;
          else                      state_nxt = WR_DATA;
        end
      end
      WR_DATA: begin
        scl    = quarter[1];
        sda_oe = ~shift_q[7];
        if (phase_end && bit_cnt == 3'd0) state_nxt = WR_ACK;
      end
      WR_ACK: begin
        scl = quarter[1];
        if (phase_end) state_nxt = STOP;
      end
      RD_DATA: begin
        scl = quarter[1];
        if (phase_end && bit_cnt == 3'd0) state_nxt = RD_NACK;
      end
      RD_NACK: begin
        scl = quarter[1];
        if (phase_end) state_nxt = STOP;
      end
      STOP: begin
        scl    = (quarter != Q0);
        sda_oe = ~quarter[1];
        if (phase_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SDA is only sampled in states where the master has released it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rw_q      <= I2C_WRITE;
      wr_byte_q <= 8'h00;
      shift_q   <= 8'h00;
      bit_cnt   <= 3'd0;
      sda_smp   <= 1'b0;
      rddata_q  <= 8'h00;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            rw_q      <= i_rw;
            wr_byte_q <= i_wrdata;
            shift_q   <= {i_addr, i_rw};
            bit_cnt   <= 3'd7;
            ack_err_q <= 1'b0;
          end
        end
        ADDR, WR_DATA: begin
          if (phase_end) begin
            shift_q <= {shift_q[6:0], 1'b0};
            bit_cnt <= bit_cnt - 3'd1;
          end
        end
        ADDR_ACK: begin
          if (smp_pt) sda_smp <= io_sda;
          if (phase_end) begin
            if (sda_smp) ack_err_q <= 1'b1;
            shift_q <= wr_byte_q;
            bit_cnt <= 3'd7;
          end
        end
        WR_ACK: begin
          if (smp_pt) sda_smp <= io_sda;
          if (phase_end && sda_smp) ack_err_q <= 1'b1;
        end
        RD_DATA: begin
          if (smp_pt)    shift_q <= {shift_q[6:0], io_sda};
          if (phase_end) bit_cnt <= bit_cnt - 3'd1;
        end
        RD_NACK: begin
          if (phase_end) rddata_q <= shift_q;
        end
        STOP: begin
          if (phase_end) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign io_sda    = sda_oe ? 1'b0 : 1'bz;
  assign o_scl     = scl;
  assign o_busy    = (state != IDLE);
  assign o_done    = done_q;
  assign o_ack_err = ack_err_q;
  assign o_rddata  = rddata_q;

endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Single-byte I2C master controller that generates START, 7-bit address + R/W, one data byte and STOP on an open-drain bus. It sits directly upstream of the `StateMachineI2C` slave, driving its `i_scl` and `io_sda`. The block lets on-chip logic issue bus transactions from a simple start/done handshake instead of bit-banging SCL/SDA.

## Interface
Parameters:
- `CLK_DIV`, default 250: `i_clk` cycles per SCL quarter-period. Minimum 2. With the default and a 100 MHz clock, the SCL period is 10 µs.

Ports:
- `i_clk`, in, 1: system clock; all logic on its rising edge.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_start`, in, 1: transaction request; sampled only in IDLE.
- `i_rw`, in, 1: 0 = write, 1 = read; captured with `i_start`.
- `i_addr`, in, 7: slave address; captured with `i_start`.
- `i_wrdata`, in, 8: write byte; captured with `i_start`.
- `o_rddata`, out, 8: byte read from the slave; updated only on a successful read.
- `o_busy`, out, 1: a transaction is in progress.
- `o_done`, out, 1: one-cycle pulse when a transaction completes.
- `o_ack_err`, out, 1: the last transaction saw a NACK; valid while `o_done` is high and held until the next start.
- `o_scl`, out, 1: SCL, push-pull. The slave does not stretch the clock.
- `io_sda`, inout, 1: SDA, open-drain. The block drives only 0 or `z`; the pull-up is external.

## Operation
- Bus time is divided into phases of 4 quarters (Q0–Q3), each quarter `CLK_DIV` clocks.
- **Data/ACK bit phase:**
  - Q0 and Q1: SCL = 0. SDA changes at the start of Q0.
  - Q2 and Q3: SCL = 1. SDA is sampled on the last clock of Q2.
- States: IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_NACK, STOP.
- **IDLE:** SCL = 1, SDA released. When `i_start` = 1, the block captures `i_addr`, `i_rw` and `i_wrdata`, clears `o_ack_err` and goes to START.
- **START phase:**
  - Q0 and Q1: SDA = 1, SCL = 1.
  - Q2: SDA = 0, SCL = 1 (this is the START condition).
  - Q3: SDA = 0, SCL = 0.
- **ADDR:** sends `{addr, rw}` MSB first over 8 bit phases.
- **ADDR_ACK:** releases SDA and samples it.
  - Sampled 1 (NACK): set `o_ack_err` and go to STOP.
  - Sampled 0, `rw` = 0: go to WR_DATA.
  - Sampled 0, `rw` = 1: go to RD_DATA.
- **WR_DATA:** sends the captured byte MSB first over 8 bits. **WR_ACK:** samples SDA; a sampled 1 sets `o_ack_err`. Then go to STOP.
- **RD_DATA:** releases SDA and shifts in 8 sampled bits, MSB first. **RD_NACK:** the master releases SDA (NACK = 1), then `o_rddata` is loaded with the shifted byte. Then go to STOP.
- **STOP phase:**
  - Q0 and Q1: SDA = 0, SCL = 0 for Q0, then SCL = 1 for Q1.
  - Q2 and Q3: SDA released (rising edge while SCL = 1 is the STOP condition).
  - After STOP, return to IDLE.
- The block never samples `io_sda` while driving it low.
- `i_start` is ignored while `o_busy` = 1. No queuing is performed.

## Timing
- Reset values: `o_scl` = 1, SDA released, `o_busy` = 0, `o_done` = 0, `o_ack_err` = 0, `o_rddata` = 8'h00, state = IDLE, counters = 0.
- Reset mid-transaction: the next cycle shows the reset values. The bus is released abruptly and no STOP is generated. This is accepted behaviour.
- `i_start` is sampled in cycle T. `o_busy` = 1 from T+1, and the first START quarter begins at T+1.
- Full transaction (write or read): 20 phases = 80·`CLK_DIV` clocks.
- Address NACK: 11 phases = 44·`CLK_DIV` clocks.
- `o_busy` falls in the cycle after the last STOP clock. `o_done` = 1 for exactly that one cycle.
- `i_start` is accepted again in the same cycle `o_done` is high, giving back-to-back transactions.
- The quarter counter wraps from `CLK_DIV`-1 to 0. The bit counter runs 7 down to 0.

## Structure
- Package `i2c_pkg`:
  - state enum `i2c_state_e`
  - `I2C_WRITE` = 1'b0, `I2C_READ` = 1'b1
  - quarter index constants Q0–Q3
- Sub-module `i2c_quarter_tick`: a `CLK_DIV` counter producing a one-cycle `o_tick` per quarter plus a 2-bit quarter index. It is cleared by `i_rst` and held in reset while IDLE.
- Top level: FSM, shift register, bit counter, and SDA output enable (`io_sda = sda_oe ? 1'b0 : 1'bz`).

## Test plan
The bench connects `StateMachineI2C` with `i_addr` = 7'b1000010 and `i_data` = 8'hA5, uses `CLK_DIV` = 250, and places a pull-up on SDA.
- **Write:** `i_rw` = 0, `i_wrdata` = 8'h3C → slave `o_rddata` = 8'h3C. `o_done` pulses once 80·250 clocks after start with `o_ack_err` = 0.
- **Read:** `i_rw` = 1 → `o_rddata` = 8'hA5, `o_ack_err` = 0. SDA is released by the master during the 9th bit after the data byte.
- **Wrong address:** `i_addr` = 7'h11 → `o_ack_err` = 1, STOP is observed, `o_done` comes after 44·250 clocks, and the slave output is unchanged.
- **Reset mid-transaction:** assert `i_rst` mid-ADDR → next cycle `o_scl` = 1, SDA = z, `o_busy` = 0. A new write then completes correctly.
- **Start while busy:** pulse `i_start` during a write → it is ignored, only one `o_done` occurs, and a back-to-back start in the `o_done` cycle is accepted.
- **Fast divider:** `CLK_DIV` = 4 → SCL period is 16 clocks, high for 8. START and STOP edges fall in Q2 of their phases.
